// File: rtl/ps2_host_if.sv
// ps2_host_if: command, completion and scan-code handshakes for ps2_host.
// slave = the PS/2 host controller, master = the system side driving it.
interface ps2_host_if;
  logic       command_valid;
  logic [7:0] command_byte;
  logic       command_ready;
  logic       command_ack_valid;
  logic       command_ack_error;
  logic       command_ack_ready;
  logic       scan_code_valid;
  logic [7:0] scan_code_byte;
  logic       scan_code_ready;

  modport master (
    output command_valid, command_byte, command_ack_ready, scan_code_ready,
    input  command_ready, command_ack_valid, command_ack_error,
           scan_code_valid, scan_code_byte
  );

  modport slave (
    input  command_valid, command_byte, command_ack_ready, scan_code_ready,
    output command_ready, command_ack_valid, command_ack_error,
           scan_code_valid, scan_code_byte
  );
endinterface

// File: rtl/ps2_host.sv
// ps2_host: PS/2 host controller. Receives device frames into a
// first-word-fall-through FIFO and transmits host commands with
// request-to-send, completion ack and watchdog.
// Optional feature macro: PS2_HOST_RETRY_EN (retry NACK/timeout up to RETRIES).
module ps2_host #(
  parameter int CLK_HZ     = 51_800_000,
  parameter int DEBOUNCE   = 255,
  parameter int FIFO_DEPTH = 8,
  parameter int RETRIES    = 2
) (
  input  logic                            clk,
  input  logic                            reset_low,
  input  logic                            ps2_clk_in,
  input  logic                            ps2_data_in,
  output logic                            ps2_clk_out,
  output logic                            ps2_clk_oe,
  output logic                            ps2_data_out,
  output logic                            ps2_data_oe,
  ps2_host_if.slave                       bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            rx_error,
  output logic                            overflow
);
  localparam int REQUEST_CYCLES  = (CLK_HZ + 9_999) / 10_000;
  localparam int WATCHDOG_CYCLES = (CLK_HZ * 2 + 999) / 1_000;
  localparam int REQ_W = $clog2(REQUEST_CYCLES + 1);
  localparam int WD_W  = $clog2(WATCHDOG_CYCLES + 1);
  localparam int DB_W  = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam int DB_MAX = (DEBOUNCE < 1) ? 0 : DEBOUNCE - 1;
  localparam int TRY_W = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = $clog2(FIFO_DEPTH + 1);
`ifdef PS2_HOST_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RX, REQUEST, TX, ACK} state_t;

  logic            rst_n;
  logic [1:0]      rst_sync;
  logic [1:0]      sync1, sync2, stable, prev;
  logic [DB_W-1:0] db_cnt [2];
  logic            fall, rise, dat;

  state_t          state;
  logic [3:0]      bit_cnt;
  logic [REQ_W-1:0] req_cnt;
  logic [WD_W-1:0] wd;
  logic            wd_expired, tx_fail;
  logic [TRY_W-1:0] tries;
  logic [7:0]      shift, rx_shift, push_byte;
  logic            rx_par, ack_bit, push;
  logic            ack_valid, ack_error;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic            full, pop, push_ok;

  // Reset asserts immediately, releases two clocks after deassertion
  always_ff @(posedge clk or negedge reset_low)
    if (!reset_low) rst_sync <= '0;
    else            rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];

  // Synchronise and debounce clock (bit 0) and data (bit 1) lines
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1  <= '1;
      sync2  <= '1;
      stable <= '1;
      prev   <= '1;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {ps2_data_in, ps2_clk_in};
      sync2 <= sync1;
      prev  <= stable;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] >= DB_W'(DB_MAX)) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end

  assign fall = prev[0] & ~stable[0];
  assign rise = ~prev[0] & stable[0];
  assign dat  = stable[1];
  assign wd_expired = (wd >= WD_W'(WATCHDOG_CYCLES));

  // Transmit failure: watchdog in TX/ACK, or NACK seen on the ack rising edge
  always_comb begin
    tx_fail = 1'b0;
    if ((state == TX || state == ACK) && wd_expired) tx_fail = 1'b1;
    if (state == ACK && rise && bit_cnt == 4'd11 && ack_bit) tx_fail = 1'b1;
  end

  // Protocol FSM with registered line drives, ack and receive results
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;    bit_cnt <= '0;   req_cnt <= '0;  wd <= '0;
      tries <= '0;      shift <= '0;     rx_shift <= '0; rx_par <= 1'b0;
      ack_bit <= 1'b0;  push <= 1'b0;    push_byte <= '0;
      ps2_clk_oe <= 1'b0; ps2_data_oe <= 1'b0; ps2_data_out <= 1'b0;
      ack_valid <= 1'b0;  ack_error <= 1'b0;   rx_error <= 1'b0;
    end else begin
      rx_error <= 1'b0;
      push     <= 1'b0;
      if (ack_valid && bus.command_ack_ready) begin
        ack_valid <= 1'b0;
        ack_error <= 1'b0;
      end
      case (state)
        IDLE: begin
          ps2_clk_oe <= 1'b0; ps2_data_oe <= 1'b0; ps2_data_out <= 1'b0;
          if (bus.command_valid && bus.command_ready) begin
            shift <= bus.command_byte;
            tries <= '0;
            req_cnt <= '0;
            ps2_clk_oe <= 1'b1; ps2_data_oe <= 1'b1;
            state <= REQUEST;
          end else if (fall && !dat) begin
            bit_cnt <= '0;
            wd <= '0;
            state <= RX;
          end
        end
        RX: begin
          if (wd_expired) begin
            rx_error <= 1'b1;
            state <= IDLE;
          end else begin
            wd <= wd + 1'b1;
            if (fall && bit_cnt <= 4'd9) begin
              if (bit_cnt < 4'd8) rx_shift <= {dat, rx_shift[7:1]};
              else if (bit_cnt == 4'd8) rx_par <= dat;
              else if (dat && (^{rx_shift, rx_par})) begin
                push <= 1'b1;
                push_byte <= rx_shift;
              end else rx_error <= 1'b1;
              bit_cnt <= bit_cnt + 1'b1;
            end else if (rise && bit_cnt == 4'd10) state <= IDLE;
          end
        end
        REQUEST: begin
          ps2_clk_oe <= 1'b1; ps2_data_oe <= 1'b1; ps2_data_out <= 1'b0;
          if (req_cnt == REQ_W'(REQUEST_CYCLES - 1)) begin
            ps2_clk_oe <= 1'b0;
            bit_cnt <= '0;
            wd <= '0;
            state <= TX;
          end else req_cnt <= req_cnt + 1'b1;
        end
        TX: begin
          wd <= wd + 1'b1;
          if (fall) begin
            if (bit_cnt < 4'd8) ps2_data_out <= shift[bit_cnt[2:0]];
            else if (bit_cnt == 4'd8) ps2_data_out <= ~^shift;
            else begin
              ps2_data_oe <= 1'b0;
              ps2_data_out <= 1'b0;
              state <= ACK;
            end
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ACK: begin
          wd <= wd + 1'b1;
          if (fall && bit_cnt == 4'd10) begin
            ack_bit <= dat;
            bit_cnt <= 4'd11;
          end else if (rise && bit_cnt == 4'd11 && !ack_bit) begin
            ack_valid <= 1'b1;
            ack_error <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ps2_clk_oe <= 1'b0; ps2_data_oe <= 1'b0; ps2_data_out <= 1'b0;
          state <= IDLE;
        end
      endcase
      // Failure overrides the per-state result: retry with the held byte or report
      if (tx_fail) begin
        if (RETRY_ON && tries < TRY_W'(RETRIES)) begin
          tries <= tries + 1'b1;
          req_cnt <= '0;
          ps2_clk_oe <= 1'b1; ps2_data_oe <= 1'b1; ps2_data_out <= 1'b0;
          state <= REQUEST;
        end else begin
          ps2_clk_oe <= 1'b0; ps2_data_oe <= 1'b0; ps2_data_out <= 1'b0;
          ack_valid <= 1'b1;
          ack_error <= 1'b1;
          state <= IDLE;
        end
      end
    end

  assign full    = (level == LW'(FIFO_DEPTH));
  assign pop     = bus.scan_code_valid & bus.scan_code_ready;
  assign push_ok = push & (~full | pop);

  // FIFO pointers, level and overflow pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0; rd_ptr <= '0; level <= '0; overflow <= 1'b0;
    end else begin
      overflow <= push & full & ~pop;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end

  // FIFO storage
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= push_byte;

  assign fifo_level            = level;
  assign bus.scan_code_valid   = (level != '0);
  assign bus.scan_code_byte    = (level != '0) ? mem[rd_ptr] : '0;
  assign bus.command_ready     = rst_n & (state == IDLE) & ~ack_valid;
  assign bus.command_ack_valid = ack_valid;
  assign bus.command_ack_error = ack_error;
  assign ps2_clk_out           = 1'b0;
endmodule

// File: tb/tb_ps2_host.sv
// tb_ps2_host: scoreboard bench for ps2_host with a behavioural PS/2 device.
module tb_ps2_host;
  localparam int CLK_HZ     = 1_000_000;
  localparam int DEBOUNCE   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int RETRIES    = 2;
  localparam int REQ_CYC    = 100;   // ceil(1e6 / 10_000)
  localparam int WD_CYC     = 2000;  // ceil(1e6 * 2 / 1000)
  localparam int HQ = 15, HP = 30;   // device clock quarter / half period in clk cycles
`ifdef PS2_HOST_RETRY_EN
  localparam int EXP_PHASES = 3;
`else
  localparam int EXP_PHASES = 1;
`endif

  logic clk = 1'b0, reset_low = 1'b1, dev_clk = 1'b1, dev_data = 1'b1;
  logic ps2_clk_out, ps2_clk_oe, ps2_data_out, ps2_data_oe;
  logic clk_line, data_line;
  logic [2:0] fifo_level;
  logic rx_error, overflow;
  int n_cmp = 0, n_bad = 0;

  logic [7:0] exp_scan[$];
  bit exp_ack[$], exp_rxerr[$], exp_ovf[$];

  ps2_host_if bus();

  assign clk_line  = dev_clk  & ~(ps2_clk_oe  & ~ps2_clk_out);
  assign data_line = dev_data & ~(ps2_data_oe & ~ps2_data_out);

  ps2_host #(.CLK_HZ(CLK_HZ), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH), .RETRIES(RETRIES)) dut (
    .clk(clk), .reset_low(reset_low),
    .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .ps2_clk_out(ps2_clk_out), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_out(ps2_data_out), .ps2_data_oe(ps2_data_oe),
    .bus(bus), .fifo_level(fifo_level), .rx_error(rx_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: compare each DUT event with the oldest expectation
  always @(negedge clk) begin
    if (bus.scan_code_valid && bus.scan_code_ready) begin
      if (exp_scan.size() == 0) check("scan_unexpected", bus.scan_code_valid, 0);
      else check("scan_byte", bus.scan_code_byte, exp_scan.pop_front());
    end
    if (bus.command_ack_valid && bus.command_ack_ready) begin
      if (exp_ack.size() == 0) check("ack_unexpected", bus.command_ack_valid, 0);
      else check("ack_error", bus.command_ack_error, exp_ack.pop_front());
    end
    if (rx_error) begin
      if (exp_rxerr.size() == 0) check("rx_error_unexpected", rx_error, 0);
      else check("rx_error_pulse", rx_error, exp_rxerr.pop_front());
    end
    if (overflow) begin
      if (exp_ovf.size() == 0) check("overflow_unexpected", overflow, 0);
      else check("overflow_pulse", overflow, exp_ovf.pop_front());
    end
  end

  // Device-to-host frame; nfalls < 11 truncates it
  task automatic dev_send(input logic [7:0] b, input logic par, input int nfalls);
    logic [10:0] f;
    f = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nfalls; i++) begin
      dev_data = f[i];
      repeat (HQ) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HQ) @(negedge clk);
    end
    dev_data = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  // Host-to-device transfer: measure request length, clock 10 bits in, answer ackbit
  task automatic dev_receive(input logic ackbit, output logic [9:0] bits, output int low, output logic ok);
    int t;
    ok = 1'b1; low = 0; bits = '0; t = 0;
    while (!ps2_clk_oe && t < 2000) begin @(negedge clk); t++; end
    if (!ps2_clk_oe) begin ok = 1'b0; return; end
    while (ps2_clk_oe && low < 20000) begin @(negedge clk); low++; end
    repeat (40) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      if (i == 10) dev_data = ackbit;
      repeat (HQ) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      dev_clk = 1'b1;
      if (i < 10) bits[i] = data_line;
      repeat (HQ) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    int t;
    @(posedge clk); #1;
    bus.command_valid = 1'b1;
    bus.command_byte  = b;
    t = 0;
    while (t < 5000) begin
      @(negedge clk);
      if (bus.command_ready) break;
      t++;
    end
    check("cmd_accepted", bus.command_ready, 1);
    @(posedge clk); #1;
    bus.command_valid = 1'b0;
  endtask

  task automatic drain();
    @(posedge clk); #1 bus.scan_code_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!bus.scan_code_valid) break;
    end
    @(posedge clk); #1 bus.scan_code_ready = 1'b0;
  endtask

  task automatic wait_ack();
    int t;
    t = 0;
    while (!bus.command_ack_valid && t < 3000) begin @(negedge clk); t++; end
    check("ack_arrived", bus.command_ack_valid, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] bits;
    int low, phases;
    logic ok;
    logic [7:0] vec_b [5];
    logic       vec_p [5];
    vec_b = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'hF0};
    vec_p = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1};

    bus.command_valid = 1'b0; bus.command_byte = '0;
    bus.command_ack_ready = 1'b0; bus.scan_code_ready = 1'b0;

    // Reset takes effect before any clock edge
    #3 reset_low = 1'b0;
    #1;
    check("reset_outputs",
          {ps2_clk_out, ps2_clk_oe, ps2_data_out, ps2_data_oe, bus.command_ready,
           bus.command_ack_valid, bus.command_ack_error, bus.scan_code_valid,
           bus.scan_code_byte, fifo_level, rx_error, overflow}, 0);
    repeat (5) @(posedge clk);
    #1 reset_low = 1'b1;
    @(negedge clk);
    check("ready_after_1_cycle", bus.command_ready, 0);
    repeat (3) @(negedge clk);
    check("ready_after_reset", bus.command_ready, 1);

    // Good frame 0x1C, parity 0
    exp_scan.push_back(8'h1C);
    dev_send(8'h1C, 1'b0, 11);
    check("level_after_1c", fifo_level, 1);
    check("head_after_1c", bus.scan_code_byte, 8'h1C);
    drain();
    check("level_drained", fifo_level, 0);

    // Bad parity frame
    exp_rxerr.push_back(1'b1);
    dev_send(8'h1C, 1'b1, 11);
    check("level_after_bad", fifo_level, 0);

    // Five good frames into a four-entry FIFO
    for (int i = 0; i < 5; i++) begin
      if (i < FIFO_DEPTH) exp_scan.push_back(vec_b[i]);
      else exp_ovf.push_back(1'b1);
      dev_send(vec_b[i], vec_p[i], 11);
    end
    check("level_full", fifo_level, 4);
    drain();
    check("level_after_drain", fifo_level, 0);

    // Command 0xED acknowledged by device; ack held until ready
    exp_ack.push_back(1'b0);
    fork
      send_cmd(8'hED);
      dev_receive(1'b0, bits, low, ok);
    join
    check("ed_request_seen", ok, 1);
    check("ed_clk_low_ge_min", low >= REQ_CYC, 1);
    check("ed_data_bits", bits[7:0], 8'hED);
    check("ed_parity", bits[8], 1);
    check("ed_stop", bits[9], 1);
    wait_ack();
    repeat (10) @(negedge clk);
    check("ack_held", bus.command_ack_valid, 1);
    check("ready_while_ack", bus.command_ready, 0);
    @(posedge clk); #1 bus.command_ack_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_after_ack", bus.command_ready, 1);

    // Device NACKs every attempt
    exp_ack.push_back(1'b1);
    phases = 0;
    fork
      send_cmd(8'hA5);
      begin
        do begin
          dev_receive(1'b1, bits, low, ok);
          if (ok) phases++;
        end while (ok && phases < 5);
      end
    join
    check("nack_phases", phases, EXP_PHASES);
    repeat (20) @(negedge clk);
    check("ready_after_nack", bus.command_ready, 1);

    // Device stops clocking after start + 4 bits
    exp_rxerr.push_back(1'b1);
    dev_send(8'h1C, 1'b0, 5);
    repeat (500) @(negedge clk);
    check("ready_mid_rx", bus.command_ready, 0);
    repeat (WD_CYC - 500) @(negedge clk);
    check("ready_after_watchdog", bus.command_ready, 1);
    check("level_after_watchdog", fifo_level, 0);

    // Reset in the middle of a transmit
    fork
      send_cmd(8'h3C);
      begin
        for (int t = 0; t < 2000 && !ps2_clk_oe; t++) @(negedge clk);
        for (int t = 0; t < 2000 && ps2_clk_oe; t++) @(negedge clk);
        repeat (40) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          repeat (HQ) @(negedge clk); dev_clk = 1'b0;
          repeat (HP) @(negedge clk); dev_clk = 1'b1;
          repeat (HQ) @(negedge clk);
        end
      end
    join
    check("tx_driving_before_reset", ps2_data_oe, 1);
    reset_low = 1'b0;
    #1;
    check("lines_released_in_reset", {ps2_clk_oe, ps2_data_oe}, 0);
    repeat (5) @(posedge clk);
    #1 reset_low = 1'b1;
    repeat (20) @(negedge clk);
    check("no_ack_after_reset", bus.command_ack_valid, 0);
    check("ready_after_reset2", bus.command_ready, 1);

    check("scan_queue_empty", exp_scan.size(), 0);
    check("ack_queue_empty", exp_ack.size(), 0);
    check("rxerr_queue_empty", exp_rxerr.size(), 0);
    check("ovf_queue_empty", exp_ovf.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
